dma_periph_buffer: RTL and testbench
====================================

Name: dma_periph_buffer

Overview:
- Elastic FIFO on the peripheral side of the DMA engine. Captures words from a peripheral source over a valid/ready handshake.
- Presents them first-word-fall-through on the DMA's peripheral_data_ready / peripheral_data / peripheral_read interface.
- Raises a watermark-based dma_req so the DMA is started only when a burst is available. Supports a flush that drains a partial burst.

Parameters:
- DATA_W, 32, data word width.
- DEPTH, 8, FIFO depth in words; power of two, >= 2.
- ADDR_W, 3, log2(DEPTH).
- WATERMARK, 4, fill level at which a burst request is raised; 1..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  peripheral source has a word.
- in_data  in  DATA_W  peripheral source word.
- in_ready  out  1  buffer can accept a word (count != DEPTH).
- peripheral_data_ready  out  1  head word valid (count != 0).
- peripheral_data  out  DATA_W  head word; 0 when empty.
- peripheral_read  in  1  DMA consumes the head word this cycle.
- flush  in  1  one-cycle request to drain a partial burst.
- dma_req  out  1  burst or flush drain pending; drives the DMA's dma_start.
- flush_done  out  1  one-cycle pulse when a flush completes.
- count  out  ADDR_W+1  current fill level, 0..DEPTH.
- overflow  out  1  sticky: in_valid seen while full.
- underflow  out  1  sticky: peripheral_read seen while empty.
- clear_err  in  1  clears overflow and underflow.

Behaviour:
- Reset (synchronous, dominates all other inputs, including mid-burst): wr_ptr=0, rd_ptr=0, count=0, state=IDLE, flush_pending=0, dma_req=0, flush_done=0, overflow=0, underflow=0. Storage array is not reset.
- Reset outputs: in_ready=1, peripheral_data_ready=0, peripheral_data=0.
- push = in_valid & in_ready. Word is written at mem[wr_ptr]; wr_ptr advances and wraps modulo DEPTH.
- pop = peripheral_read & peripheral_data_ready. rd_ptr advances and wraps modulo DEPTH.
- Count update per cycle: count += push - pop. Simultaneous push and pop leaves count unchanged and is legal at any non-full, non-empty level.
- in_ready and peripheral_data_ready are combinational from registered count only; they never depend on in_valid or peripheral_read.
- Latency: a word pushed at edge N is visible on peripheral_data with peripheral_data_ready=1 in the cycle after edge N. A pop at edge N presents the next word (or 0 when now empty) after edge N.
- Full: in_valid=1 does not push; data is dropped and overflow is set at the edge. A pop in the same cycle does not enable a push, because in_ready is based on the pre-pop count.
- Empty: peripheral_read=1 is ignored and underflow is set.
- clear_err=1 clears both sticky flags. A new error event in the same cycle wins, so the flag stays set.
- Order preserved exactly; no word duplicated or lost except on overflow.
- FSM states, evaluated on next-cycle count (count_nxt):
  - IDLE: dma_req=0.
    - If flush_pending and count_nxt>0 -> FLUSH.
    - Else if count_nxt>=WATERMARK -> BURST.
    - Else if flush_pending and count_nxt==0 -> stay IDLE, pulse flush_done, clear flush_pending.
  - BURST: dma_req=1. Stay until count_nxt==0 -> IDLE. A flush arriving here is absorbed into the burst: when empty, pulse flush_done and clear flush_pending.
  - FLUSH: dma_req=1. When count_nxt==0 -> IDLE, pulse flush_done, clear flush_pending.
- flush=1 sets flush_pending at the edge. Repeated flush while pending has no extra effect.
- dma_req and flush_done are registered; dma_req rises the cycle after the edge at which the threshold is reached.
- Pointer arithmetic is ADDR_W bits with natural wrap. count is ADDR_W+1 bits and never exceeds DEPTH or goes below 0.

Test Plan:
- Reset then idle -> in_ready=1, peripheral_data_ready=0, peripheral_data=0, count=0, dma_req=0, flags 0.
- Push 0xA0..0xA3 on consecutive cycles, no reads -> count=4; dma_req=1 from the cycle after the 4th push. Then hold peripheral_read=1 -> reads 0xA0,0xA1,0xA2,0xA3 in order; dma_req=0 the cycle after count reaches 0.
- Push 8 words 0x10..0x17, then in_valid=1 with 0xFF -> in_ready=0, count stays 8, overflow=1, 0xFF never read. clear_err -> overflow=0.
- Full FIFO, simultaneous in_valid and peripheral_read for 1 cycle -> pop only, count=7. Next cycle push and pop together -> count stays 7, wrap-around order preserved over 20 words.
- Push 2 words, pulse flush -> FLUSH; dma_req=1; after 2 reads, dma_req=0 and flush_done pulses for exactly 1 cycle. Flush while empty -> flush_done pulse next cycle, dma_req stays 0.
- peripheral_read while empty -> underflow=1, count stays 0. Assert reset mid-BURST at count=5 -> next cycle count=0, dma_req=0, all flags 0.

Source files
------------

// File: rtl/dma_periph_buffer.sv
// Peripheral-side elastic FIFO for the DMA engine: first-word-fall-through read port,
// watermark burst request, flush drain of partial bursts and sticky error flags.
module dma_periph_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 8,
    parameter int ADDR_W    = 3,
    parameter int WATERMARK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              peripheral_data_ready,
    output logic [DATA_W-1:0] peripheral_data,
    input  logic              peripheral_read,
    input  logic              flush,
    output logic              dma_req,
    output logic              flush_done,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clear_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] WM_LEVEL   = (ADDR_W+1)'(WATERMARK);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    state_t            r_state;
    logic              r_flush_pending;
    logic              r_dma_req;
    logic              r_flush_done;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_push;
    logic              w_pop;
    logic [ADDR_W:0]   w_count_nxt;
    state_t            w_state_nxt;
    logic              w_flush_done_nxt;
    logic              w_clear_pending;

    // Handshake readiness comes only from the registered fill level.
    assign in_ready              = (r_count != FULL_LEVEL);
    assign peripheral_data_ready = (r_count != '0);
    assign peripheral_data       = peripheral_data_ready ? r_mem[r_rd_ptr] : '0;
    assign count                 = r_count;
    assign dma_req               = r_dma_req;
    assign flush_done            = r_flush_done;
    assign overflow              = r_overflow;
    assign underflow             = r_underflow;

    assign w_push = in_valid & in_ready;
    assign w_pop  = peripheral_read & peripheral_data_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (ADDR_W+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count <= w_count_nxt;
            // A fresh error event outranks clear_err in the same cycle.
            r_overflow  <= (r_overflow & ~clear_err) | (in_valid & ~in_ready);
            r_underflow <= (r_underflow & ~clear_err) | (peripheral_read & ~peripheral_data_ready);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        w_clear_pending  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_flush_pending && (w_count_nxt != '0)) begin
                    w_state_nxt = FLUSH;
                end else if (w_count_nxt >= WM_LEVEL) begin
                    w_state_nxt = BURST;
                end else if (r_flush_pending) begin
                    w_flush_done_nxt = 1'b1;
                    w_clear_pending  = 1'b1;
                end
            end
            BURST: begin
                // A flush raised mid-burst completes when the burst drains.
                if (w_count_nxt == '0) begin
                    w_state_nxt      = IDLE;
                    w_flush_done_nxt = r_flush_pending;
                    w_clear_pending  = r_flush_pending;
                end
            end
            FLUSH: begin
                if (w_count_nxt == '0) begin
                    w_state_nxt      = IDLE;
                    w_flush_done_nxt = 1'b1;
                    w_clear_pending  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_flush_pending <= 1'b0;
            r_dma_req       <= 1'b0;
            r_flush_done    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_flush_pending <= (r_flush_pending & ~w_clear_pending) | flush;
            r_dma_req       <= (w_state_nxt != IDLE);
            r_flush_done    <= w_flush_done_nxt;
        end
    end

endmodule

// File: tb/tb_dma_periph_buffer.sv
// Scoreboard bench for dma_periph_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the buffer and its request logic.
module tb_dma_periph_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;
    localparam int WM     = 4;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              peripheral_data_ready;
    logic [DATA_W-1:0] peripheral_data;
    logic              peripheral_read;
    logic              flush;
    logic              dma_req;
    logic              flush_done;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
    logic              clear_err;

    dma_periph_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WATERMARK(WM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .peripheral_data_ready(peripheral_data_ready),
        .peripheral_data(peripheral_data),
        .peripheral_read(peripheral_read),
        .flush(flush),
        .dma_req(dma_req),
        .flush_done(flush_done),
        .count(count),
        .overflow(overflow),
        .underflow(underflow),
        .clear_err(clear_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: fill level, "request active" flag, pending flush, pulses and flags.
    int                mCount   = 0;
    bit                mReq     = 0;
    bit                mPending = 0;
    bit                mDone    = 0;
    bit                mOvf     = 0;
    bit                mUnf     = 0;
    logic [DATA_W-1:0] expQ[$];
    bit                monitorOn = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, predicts the effect of the coming edge, then commits it.
    task automatic applyStimulus(input bit rst, input bit v, input logic [DATA_W-1:0] d,
                                 input bit r, input bit f, input bit c);
        int  nCount;
        bit  push, pop, nReq, nPending, nDone, nOvf, nUnf, clearPend;
        reset           = rst;
        in_valid        = v;
        in_data         = d;
        peripheral_read = r;
        flush           = f;
        clear_err       = c;
        push      = v && (mCount != DEPTH);
        pop       = r && (mCount != 0);
        nCount    = mCount + int'(push) - int'(pop);
        nOvf      = (v && mCount == DEPTH) || (mOvf && !c);
        nUnf      = (r && mCount == 0) || (mUnf && !c);
        nReq      = mReq;
        nDone     = 0;
        clearPend = 0;
        if (!mReq) begin
            if (mPending && nCount > 0) nReq = 1;
            else if (nCount >= WM) nReq = 1;
            else if (mPending) begin
                nDone     = 1;
                clearPend = 1;
            end
        end else if (nCount == 0) begin
            nReq = 0;
            if (mPending) begin
                nDone     = 1;
                clearPend = 1;
            end
        end
        nPending = f || (mPending && !clearPend);
        if (!rst && push) expQ.push_back(d);
        @(posedge clk);
        #1;
        if (rst) begin
            mCount = 0; mReq = 0; mPending = 0; mDone = 0; mOvf = 0; mUnf = 0;
            expQ.delete();
        end else begin
            mCount = nCount; mReq = nReq; mPending = nPending;
            mDone = nDone; mOvf = nOvf; mUnf = nUnf;
        end
        monitorOn = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, 0, 0, 0);
    endtask

    // Monitor: compares every visible output against the model and consumes popped words.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkOutput("inReady", 32'(in_ready), 32'(mCount != DEPTH));
            checkOutput("dataReady", 32'(peripheral_data_ready), 32'(mCount != 0));
            checkOutput("count", 32'(count), 32'(mCount));
            checkOutput("dmaReq", 32'(dma_req), 32'(mReq));
            checkOutput("flushDone", 32'(flush_done), 32'(mDone));
            checkOutput("overflow", 32'(overflow), 32'(mOvf));
            checkOutput("underflow", 32'(underflow), 32'(mUnf));
            if (mCount > 0) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboardEmpty actual=%0h required=none", peripheral_data);
                end else begin
                    checkOutput("headData", peripheral_data, expQ[0]);
                    if (peripheral_read) void'(expQ.pop_front());
                end
            end else begin
                checkOutput("emptyData", peripheral_data, '0);
            end
        end
    end

    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int validPct, readPct;
        reset = 1; in_valid = 0; in_data = '0; peripheral_read = 0; flush = 0; clear_err = 0;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, '0, 0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0, 0);
        idle(2);
        checkOutput("rstCount", 32'(count), 0);
        checkOutput("rstInReady", 32'(in_ready), 1);
        checkOutput("rstData", peripheral_data, 0);

        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 32'hA0 + i, 0, 0, 0);
        checkOutput("reqAtWatermark", 32'(dma_req), 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("reqDrained", 32'(dma_req), 0);
        idle(2);

        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 32'h10 + i, 0, 0, 0);
        applyStimulus(0, 1, 32'hFF, 0, 0, 0);
        checkOutput("fullCount", 32'(count), 8);
        checkOutput("ovfSet", 32'(overflow), 1);
        applyStimulus(0, 0, '0, 0, 0, 1);
        checkOutput("ovfCleared", 32'(overflow), 0);

        applyStimulus(0, 1, 32'h55, 1, 0, 0);
        checkOutput("fullPopOnly", 32'(count), 7);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 32'h100 + i, 1, 0, 0);
        checkOutput("steadyCount", 32'(count), 7);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, '0, 1, 0, 0);
        applyStimulus(0, 0, '0, 0, 0, 1);

        applyStimulus(0, 1, 32'hC0, 0, 0, 0);
        applyStimulus(0, 1, 32'hC1, 0, 0, 0);
        applyStimulus(0, 0, '0, 0, 1, 0);
        idle(2);
        checkOutput("flushReq", 32'(dma_req), 1);
        applyStimulus(0, 0, '0, 1, 0, 0);
        applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("flushDonePulse", 32'(flush_done), 1);
        idle(2);
        applyStimulus(0, 0, '0, 0, 1, 0);
        idle(1);
        checkOutput("flushEmptyDone", 32'(flush_done), 1);
        checkOutput("flushEmptyReq", 32'(dma_req), 0);
        idle(2);

        applyStimulus(0, 0, '0, 1, 0, 0);
        checkOutput("unfSet", 32'(underflow), 1);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'hD0 + i, 0, 0, 0);
        applyStimulus(1, 0, '0, 0, 0, 0);
        checkOutput("midBurstRstCount", 32'(count), 0);
        checkOutput("midBurstRstReq", 32'(dma_req), 0);
        checkOutput("midBurstRstUnf", 32'(underflow), 0);
        idle(2);

        validPct = 60;
        readPct  = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) begin
                validPct = $urandom_range(10, 95);
                readPct  = $urandom_range(10, 95);
            end
            applyStimulus($urandom_range(0, 299) == 0,
                          $urandom_range(0, 99) < validPct,
                          $urandom,
                          $urandom_range(0, 99) < readPct,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 29) == 0);
        end
        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
